// File: rtl/switch_event_register_if.sv
// Switch-pin / display-side signal bundle for switch_event_register.
interface switch_event_register_if #(
   parameter int NUM_SW = 4,
   parameter int WIDTH  = 4
);
   logic [NUM_SW-1:0] i_Switch;
   logic [WIDTH-1:0]  o_Value;
   logic [NUM_SW-1:0] o_Press_Pulse;
   logic [NUM_SW-1:0] o_Debounced;

   modport master (output i_Switch, input o_Value, o_Press_Pulse, o_Debounced);
   modport slave  (input i_Switch, output o_Value, o_Press_Pulse, o_Debounced);
endinterface

// File: rtl/switch_event_register.sv
// Debounced switch bank driving a toggle (MODE 0) or up/down/clear (MODE 1) register.
// Optional auto-repeat while a switch is held: define SWITCH_AUTOREPEAT_EN.
module switch_event_lane #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int REPEAT_DELAY   = 12500000,
   parameter int REPEAT_PERIOD  = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb,
   output logic rise,
   output logic rep
);
   localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;

   logic          sync1, sync2, deb_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         if (sync2 != deb) begin
            if (cnt == CW'(DEBOUNCE_LIMIT - 1)) begin
               deb <= sync2;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = deb & ~deb_q;

`ifdef SWITCH_AUTOREPEAT_EN
   localparam int HW     = $clog2(REPEAT_DELAY + 1);
   localparam int RELOAD = REPEAT_DELAY - REPEAT_PERIOD + 1;

   // hold counts edges since the press; reloading on a repeat makes the next hit land REPEAT_PERIOD later
   logic [HW-1:0] hold;

   always_ff @(posedge clk) begin
      if (rst || !deb)  hold <= '0;
      else if (rise)    hold <= HW'(1);
      else if (rep)     hold <= HW'(RELOAD);
      else              hold <= hold + HW'(1);
   end

   assign rep = deb & (hold == HW'(REPEAT_DELAY));
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
   assign rep = 1'b0;
`endif
endmodule

module switch_event_register #(
   parameter int NUM_SW         = 4,
   parameter int WIDTH          = 4,
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int MODE           = 0,
   parameter int REPEAT_DELAY   = 12500000,
   parameter int REPEAT_PERIOD  = 2500000
) (
   input logic                   i_Clk,
   input logic                   i_Reset,
   switch_event_register_if.slave bus
);
   logic [NUM_SW-1:0] sw, deb, rise, rep, ev, pulse;
   logic [WIDTH-1:0]  value, value_next;

   assign sw = bus.i_Switch;

   switch_event_lane #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_lane [NUM_SW-1:0] (
      .clk  (i_Clk),
      .rst  (i_Reset),
      .raw  (sw),
      .deb  (deb),
      .rise (rise),
      .rep  (rep)
   );

   // The clear switch of the counter fires once per press, never on repeat
   always_comb begin
      ev = '0;
      for (int k = 0; k < NUM_SW; k++)
         ev[k] = rise[k] | (((MODE == 1) && (k == 2)) ? 1'b0 : rep[k]);
   end

   generate
      if (MODE == 0) begin : g_toggle
         assign value_next = value ^ WIDTH'(ev);
      end else begin : g_count
         logic up, dn, clr;
         assign up  = ev[0];
         assign dn  = ev[(NUM_SW > 1) ? 1 : 0];
         assign clr = (NUM_SW > 2) ? ev[(NUM_SW > 2) ? 2 : 0] : 1'b0;

         always_comb begin
            value_next = value;
            if (clr)             value_next = '0;
            else if (up && !dn)  value_next = value + WIDTH'(1);
            else if (dn && !up)  value_next = value - WIDTH'(1);
         end
      end
   endgenerate

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         value <= '0;
         pulse <= '0;
      end else begin
         value <= value_next;
         pulse <= ev;
      end
   end

   assign bus.o_Value       = value;
   assign bus.o_Press_Pulse = pulse;
   assign bus.o_Debounced   = deb;
endmodule

// File: tb/tb_switch_event_register.sv
// Scoreboard bench: a toggle instance and a counter instance share clock/reset; a reference model
// built on raw-sample history feeds expected outputs to a monitor that compares every cycle.
module tb_switch_event_register;
   localparam int L  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk, rst;
   int   nchk = 0, nerr = 0;

   typedef struct packed {
      logic [3:0] v0, p0, d0, v1, p1, d1;
   } exp_t;
   exp_t q[$];

   switch_event_register_if #(.NUM_SW(4), .WIDTH(4)) if0 ();
   switch_event_register_if #(.NUM_SW(4), .WIDTH(4)) if1 ();

   switch_event_register #(.NUM_SW(4), .WIDTH(4), .DEBOUNCE_LIMIT(L), .MODE(0),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      u0 (.i_Clk(clk), .i_Reset(rst), .bus(if0.slave));
   switch_event_register #(.NUM_SW(4), .WIDTH(4), .DEBOUNCE_LIMIT(L), .MODE(1),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
      u1 (.i_Clk(clk), .i_Reset(rst), .bus(if1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: a switch level is accepted once the raw samples taken 2..L+1 edges ago
   // all disagree with the current level; presses and repeats are counted in edges since the press.
   logic [3:0] hist [2][0:L+1];
   logic [3:0] mdeb [2], mprv [2], mval [2], mpls [2];
   int         since [2][4];

   initial begin : model
      logic [3:0] raw, ev;
      int         t;
      bit         rep, flip;
      exp_t       e;
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            raw = (d == 0) ? if0.i_Switch : if1.i_Switch;
            if (rst) begin
               for (int j = 0; j <= L + 1; j++) hist[d][j] = '0;
               mdeb[d] = '0; mprv[d] = '0; mval[d] = '0; mpls[d] = '0;
               for (int k = 0; k < 4; k++) since[d][k] = -1;
            end else begin
               ev = '0;
               for (int k = 0; k < 4; k++) begin
                  rep = 1'b0;
                  t   = 0;
`ifdef SWITCH_AUTOREPEAT_EN
                  if (mdeb[d][k] && since[d][k] >= 0 && !(d == 1 && k == 2)) begin
                     t   = since[d][k] + 1;
                     rep = (t == RD) || (t > RD && ((t - RD) % RP) == 0);
                  end
`endif
                  ev[k] = (mdeb[d][k] & ~mprv[d][k]) | rep;
                  if (!mdeb[d][k])                     since[d][k] = -1;
                  else if (mdeb[d][k] & ~mprv[d][k])   since[d][k] = 0;
                  else if (since[d][k] >= 0)           since[d][k] = since[d][k] + 1;
               end
               if (d == 0)                 mval[d] = mval[d] ^ ev;
               else if (ev[2])             mval[d] = 4'h0;
               else if (ev[0] && !ev[1])   mval[d] = mval[d] + 4'd1;
               else if (ev[1] && !ev[0])   mval[d] = mval[d] - 4'd1;
               mpls[d] = ev;
               mprv[d] = mdeb[d];
               for (int j = L + 1; j > 0; j--) hist[d][j] = hist[d][j-1];
               hist[d][0] = raw;
               for (int k = 0; k < 4; k++) begin
                  flip = 1'b1;
                  for (int j = 2; j <= L + 1; j++)
                     if (hist[d][j][k] == mdeb[d][k]) flip = 1'b0;
                  if (flip) mdeb[d][k] = ~mdeb[d][k];
               end
            end
         end
         e.v0 = mval[0]; e.p0 = mpls[0]; e.d0 = mdeb[0];
         e.v1 = mval[1]; e.p1 = mpls[1]; e.d1 = mdeb[1];
         q.push_back(e);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_toggle", {20'd0, if0.o_Value, if0.o_Press_Pulse, if0.o_Debounced},
                             {20'd0, e.v0, e.p0, e.d0});
            chk("sb_count",  {20'd0, if1.o_Value, if1.o_Press_Pulse, if1.o_Debounced},
                             {20'd0, e.v1, e.p1, e.d1});
         end
      end
   end

   task automatic press1(input logic [3:0] pat);
      if1.i_Switch = pat;
      cyc(6);
      if1.i_Switch = '0;
      cyc(10);
   endtask

   initial begin : stim
      int  n;
      bit  seen;
      rst = 1'b1;
      if0.i_Switch = '0;
      if1.i_Switch = '0;
      cyc(2);
      chk("reset_value0", {28'd0, if0.o_Value}, 32'd0);
      chk("reset_deb1",   {28'd0, if1.o_Debounced}, 32'd0);
      rst = 1'b0;

      // toggle: switch 1 held 20 cycles, pulse exactly after the 7th edge
      if0.i_Switch = 4'b0010;
      cyc(6);
      chk("t_no_early_pulse", {28'd0, if0.o_Press_Pulse}, 32'd0);
      cyc(1);
      chk("t_pulse_edge7", {28'd0, if0.o_Press_Pulse}, 32'h2);
      chk("t_value_edge7", {28'd0, if0.o_Value}, 32'h2);
      cyc(1);
      chk("t_pulse_one_cycle", {28'd0, if0.o_Press_Pulse}, 32'd0);
      cyc(12);
      if0.i_Switch = '0;
      cyc(12);
      chk("t_release_no_change", {28'd0, if0.o_Value}, 32'h2);
      if0.i_Switch = 4'b0010;
      cyc(8);
      if0.i_Switch = '0;
      cyc(10);
      chk("t_second_press", {28'd0, if0.o_Value}, 32'h0);

      // glitches shorter than the debounce window
      repeat (5) begin
         if0.i_Switch = 4'b0001;
         cyc(3);
         if0.i_Switch = '0;
         cyc(3);
      end
      cyc(8);
      chk("glitch_value", {28'd0, if0.o_Value}, 32'd0);
      chk("glitch_deb",   {28'd0, if0.o_Debounced}, 32'd0);

      // counter: wrap both ways, up+down cancel, clear wins
      press1(4'b0010);
      chk("c_down_wrap", {28'd0, if1.o_Value}, 32'hF);
      press1(4'b0001);
      chk("c_up_wrap", {28'd0, if1.o_Value}, 32'h0);
      press1(4'b0010);
      chk("c_down", {28'd0, if1.o_Value}, 32'hF);
      press1(4'b0011);
      chk("c_up_down", {28'd0, if1.o_Value}, 32'hF);
      press1(4'b0101);
      chk("c_clear_up", {28'd0, if1.o_Value}, 32'h0);
      press1(4'b1000);
      chk("c_sw3_no_value", {28'd0, if1.o_Value}, 32'h0);

      // held up switch: one press, plus repeats at +10, +13, ... when enabled
      if1.i_Switch = 4'b0001;
      cyc(30);
      if1.i_Switch = '0;
      cyc(12);
`ifdef SWITCH_AUTOREPEAT_EN
      chk("c_hold_repeat", {28'd0, if1.o_Value}, 32'h8);
`else
      chk("c_hold_single", {28'd0, if1.o_Value}, 32'h1);
`endif

      // reset in mid-debounce while switch 2 is held
      if0.i_Switch = 4'b0100;
      cyc(4);
      rst = 1'b1;
      cyc(1);
      chk("rst_value",  {28'd0, if0.o_Value, if1.o_Value}, 32'd0);
      chk("rst_pulse",  {28'd0, if0.o_Press_Pulse}, 32'd0);
      rst = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         cyc(1);
         if (if0.o_Press_Pulse[2]) begin
            seen = 1'b1;
            n = i;
         end
      end
      chk("rst_requalify_edges", n, 7);
      if0.i_Switch = '0;
      cyc(10);

      // random patterns with occasional resets
      for (int i = 0; i < 80; i++) begin
         if0.i_Switch = 4'($urandom_range(0, 15));
         if1.i_Switch = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
         end
         cyc($urandom_range(1, 14));
      end
      if0.i_Switch = '0;
      if1.i_Switch = '0;
      cyc(20);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/switch_event_register.md
Name: switch_event_register

Overview:
- Parametrised successor to the per-switch toggle nibble: NUM_SW raw switch inputs, each synchronised and debounced, with press-edge detection.
- Accepted presses drive a WIDTH-bit register in one of two modes:
  - MODE 0: per-bit toggle.
  - MODE 1: up/down/clear counter.
- Sits between board switch pins and display logic (7-segment decoder, LEDs). Replaces ad-hoc edge detectors that lack debounce.

Parameters:
- NUM_SW, 4: number of switch inputs, 1..8.
- WIDTH, 4: output register width, 1..16. MODE 0 requires WIDTH >= NUM_SW.
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles required to accept a level change, >= 2.
- MODE, 0: 0 = toggle, 1 = up/down/clear counter. MODE 1 requires NUM_SW >= 2.
- REPEAT_DELAY, 12500000: cycles from accepted press to first auto-repeat. Used only with SWITCH_AUTOREPEAT_EN.
- REPEAT_PERIOD, 2500000: cycles between subsequent auto-repeats. Used only with SWITCH_AUTOREPEAT_EN.

Ports:
- i_Clk, input, 1: sole clock. All state updates on posedge i_Clk.
- i_Reset, input, 1: synchronous, active-high reset.
- i_Switch, input, NUM_SW: raw asynchronous switch levels, 1 = pressed.
- o_Value, output, WIDTH: register value.
- o_Press_Pulse, output, NUM_SW: one-cycle strobe per switch on each accepted event (press or repeat).
- o_Debounced, output, NUM_SW: debounced switch levels.

Behaviour:
- Reset (i_Reset high at a posedge):
  - o_Value = 0, o_Press_Pulse = 0, o_Debounced = 0.
  - Synchroniser flops, debounce counters and repeat counters all = 0.
  - Reset dominates every other event in that cycle.
  - Reset mid-debounce or mid-hold discards the partial count. A switch still high after reset must requalify the full DEBOUNCE_LIMIT before producing an event.
- Synchroniser: two flops per switch, sync1 then sync2.
- Debounce, per switch:
  - Counter increments on each edge where sync2 != debounced.
  - Counter returns to 0 on any edge where they match.
  - On an edge where the counter equals DEBOUNCE_LIMIT-1 and a mismatch persists: debounced <= sync2 and counter <= 0.
  - A pulse shorter than DEBOUNCE_LIMIT cycles at sync2 produces no change, in either direction.
- Press event: debounced rising (debounced high, previous-cycle debounced low). Releases generate no events.
- Latency: raw input rises before edge 1 and stays high.
  - Debounced goes high after edge DEBOUNCE_LIMIT+2.
  - o_Press_Pulse bit and o_Value update are registered and visible after edge DEBOUNCE_LIMIT+3.
  - Pulse lasts exactly one cycle.
- MODE 0 (toggle):
  - Event on switch k inverts o_Value[k].
  - Simultaneous events on several switches each invert their own bit in the same cycle.
  - Bits NUM_SW..WIDTH-1 stay 0.
- MODE 1 (counter):
  - Switch 0 = up, switch 1 = down, switch 2 (if present) = clear. Switches 3+ only produce o_Press_Pulse.
  - Arithmetic is modulo 2^WIDTH: 2^WIDTH-1 plus 1 gives 0; 0 minus 1 gives 2^WIDTH-1.
  - Simultaneous events, by priority:
    - clear with anything: value becomes 0.
    - up and down together: value unchanged.
- o_Debounced mirrors the internal debounced flops with no extra delay.

Optional Feature:
- Macro: SWITCH_AUTOREPEAT_EN.
- Defined: each switch gets a hold counter, running while debounced is high.
  - Extra event REPEAT_DELAY cycles after the accepted press event.
  - Further events every REPEAT_PERIOD cycles thereafter.
  - Repeat events are identical to press events (pulse plus value update).
  - Debounced falling stops repeats at once and zeroes the hold counter. No repeat event in that cycle.
  - Clear (MODE 1) is never repeated; it fires once per press.
- Undefined: no hold counters are instantiated and one press gives exactly one event. REPEAT_* parameters are accepted and ignored.

Test Plan:
- Bench parameters: DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- MODE 0, NUM_SW=4, WIDTH=4, press switch 1 held 20 cycles then released -> o_Value 4'b0010 and o_Press_Pulse 4'b0010 for exactly one cycle after edge 7. Release produces no change. Second press -> 4'b0000.
- Glitch: switch 0 high 3 cycles then low, repeated 5 times -> o_Value stays 0, o_Press_Pulse never asserts, o_Debounced stays 0.
- MODE 1, WIDTH=4, from 4'hF press up -> 4'h0. Press down -> 4'hF. Up and down raised on the same cycle -> value unchanged. Clear plus up on the same cycle -> 4'h0.
- Reset: assert i_Reset for 1 cycle at edge 5 while switch 2 held high -> all outputs 0. First pulse appears 7 edges after reset release, not before.
- SWITCH_AUTOREPEAT_EN, MODE 1, up held 30 cycles from 0 -> events at press, press+10, +13, +16, ... until release. o_Value counts 1,2,3,... with no event after debounced falls.
- Without SWITCH_AUTOREPEAT_EN, same stimulus -> o_Value = 1, exactly one pulse.
